// File: rtl/game_flow_sequencer.sv
// Game flow sequencer: sequences IDLE / PLAY / HIT / OVER for the dragon game.
// Inputs are sampled only on frame_end. All outputs come from registers and
// change one clock after the sampling edge.
// Optional feature: define GAME_FLOW_SCORE_EN to build the 8-bit score
// register. Without it, score is tied to 0.
module game_flow_sequencer #(
  parameter int START_LIVES      = 3,
  parameter int HIT_PAUSE_FRAMES = 30,
  parameter int INVULN_FRAMES    = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_end,
  input  logic       start,
  input  logic       player_dragon_hit,
  input  logic       sword_dragon_hit,
  input  logic       sheep_dragon_hit,
  output logic [1:0] state,
  output logic [1:0] lives,
  output logic       play_enable,
  output logic       flash,
  output logic [1:0] length_update,
  output logic       snare_trigger,
  output logic [7:0] score,
  output logic       game_over
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_HIT  = 2'b10,
    S_OVER = 2'b11
  } state_t;

  localparam logic [1:0] LIVES_INIT  = 2'(START_LIVES);
  localparam logic [7:0] PAUSE_LOAD  = 8'(HIT_PAUSE_FRAMES - 1);
  localparam logic [7:0] INVULN_LOAD = 8'(INVULN_FRAMES);

  state_t     state_reg, state_next;
  logic [1:0] lives_reg, lives_next;
  logic [7:0] pause_reg, pause_next;
  logic [7:0] invuln_reg, invuln_next;
  logic       start_prev_reg, start_prev_next;
  logic [1:0] length_reg, length_next;
  logic       snare_reg, snare_next;

  // A press counts only on a rising level seen across two frame samples.
  logic start_event;
  // A player hit is taken only when the invulnerability window has run out.
  logic hit_taken;

  assign start_event = start & ~start_prev_reg;
  assign hit_taken   = player_dragon_hit & (invuln_reg == 8'd0);

  // State and counter registers; reset wins over any coincident frame_end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      lives_reg      <= LIVES_INIT;
      pause_reg      <= 8'd0;
      invuln_reg     <= 8'd0;
      start_prev_reg <= 1'b1;
      length_reg     <= 2'b00;
      snare_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      lives_reg      <= lives_next;
      pause_reg      <= pause_next;
      invuln_reg     <= invuln_next;
      start_prev_reg <= start_prev_next;
      length_reg     <= length_next;
      snare_reg      <= snare_next;
    end
  end

  // Next-state and per-frame actions; pulses default low so they last one clock.
  always_comb begin
    state_next      = state_reg;
    lives_next      = lives_reg;
    pause_next      = pause_reg;
    invuln_next     = invuln_reg;
    start_prev_next = start_prev_reg;
    length_next     = 2'b00;
    snare_next      = 1'b0;
    if (frame_end) begin
      start_prev_next = start;
      case (state_reg)
        S_IDLE: begin
          lives_next = LIVES_INIT;
          if (start_event) begin
            state_next  = S_PLAY;
            invuln_next = 8'd0;
          end
        end
        S_PLAY: begin
          if (hit_taken) begin
            // Leaving PLAY this frame, so sword/sheep actions are dropped.
            if (lives_reg > 2'd1) begin
              lives_next = lives_reg - 2'd1;
              pause_next = PAUSE_LOAD;
              state_next = S_HIT;
            end else begin
              lives_next = 2'd0;
              state_next = S_OVER;
            end
          end else begin
            if (invuln_reg != 8'd0) begin
              invuln_next = invuln_reg - 8'd1;
            end
            if (sword_dragon_hit) begin
              snare_next = 1'b1;
            end
            // Grow and shrink in the same frame cancel out.
            case ({sword_dragon_hit, sheep_dragon_hit})
              2'b10:   length_next = 2'b10;
              2'b01:   length_next = 2'b01;
              default: length_next = 2'b00;
            endcase
          end
        end
        S_HIT: begin
          if (pause_reg == 8'd0) begin
            state_next  = S_PLAY;
            invuln_next = INVULN_LOAD;
          end else begin
            pause_next = pause_reg - 8'd1;
          end
        end
        S_OVER: begin
          lives_next = 2'd0;
          if (start_event) begin
            state_next = S_IDLE;
            lives_next = LIVES_INIT;
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

`ifdef GAME_FLOW_SCORE_EN
  logic [7:0] score_reg;
  logic       score_clear;
  logic       score_inc;

  assign score_clear = frame_end & (state_reg == S_IDLE) & start_event;
  assign score_inc   = frame_end & (state_reg == S_PLAY) & ~hit_taken & sword_dragon_hit;

  // Score counts sword hits, saturating at 255, cleared when a game starts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      score_reg <= 8'd0;
    end else if (score_clear) begin
      score_reg <= 8'd0;
    end else if (score_inc && (score_reg != 8'hFF)) begin
      score_reg <= score_reg + 8'd1;
    end
  end

  assign score = score_reg;
`else
  assign score = 8'd0;
`endif

  assign state         = state_reg;
  assign lives         = lives_reg;
  assign play_enable   = (state_reg == S_PLAY);
  assign game_over     = (state_reg == S_OVER);
  assign flash         = ((state_reg == S_PLAY) && (invuln_reg != 8'd0)) ? invuln_reg[2] : 1'b0;
  assign length_update = length_reg;
  assign snare_trigger = snare_reg;

endmodule

// File: tb/tb_game_flow_sequencer.sv
// Self-checking bench for game_flow_sequencer: a behavioural model pushes
// expected outputs into a scoreboard each time stimulus is driven, and the
// entries are popped and compared after the DUT clock edge.
module tb_game_flow_sequencer;

  localparam int T_START  = 3;
  localparam int T_PAUSE  = 30;
  localparam int T_INVULN = 60;
`ifdef GAME_FLOW_SCORE_EN
  localparam bit SCORE_EN = 1'b1;
`else
  localparam bit SCORE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_end;
  logic       start;
  logic       player_dragon_hit;
  logic       sword_dragon_hit;
  logic       sheep_dragon_hit;
  logic [1:0] state;
  logic [1:0] lives;
  logic       play_enable;
  logic       flash;
  logic [1:0] length_update;
  logic       snare_trigger;
  logic [7:0] score;
  logic       game_over;

  game_flow_sequencer #(
    .START_LIVES(T_START),
    .HIT_PAUSE_FRAMES(T_PAUSE),
    .INVULN_FRAMES(T_INVULN)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_end(frame_end),
    .start(start),
    .player_dragon_hit(player_dragon_hit),
    .sword_dragon_hit(sword_dragon_hit),
    .sheep_dragon_hit(sheep_dragon_hit),
    .state(state),
    .lives(lives),
    .play_enable(play_enable),
    .flash(flash),
    .length_update(length_update),
    .snare_trigger(snare_trigger),
    .score(score),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] lv;
    logic       pe;
    logic       fl;
    logic [1:0] lu;
    logic       sn;
    logic [7:0] sc;
    logic       go;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Behavioural model of the game flow
  int m_state, m_lives, m_score, m_pause, m_inv, m_lu, m_sn;
  bit m_sp;

  task automatic model_reset();
    m_state = 0; m_lives = T_START; m_score = 0; m_pause = 0; m_inv = 0;
    m_sp = 1'b1; m_lu = 0; m_sn = 0;
  endtask

  task automatic model_step(input bit st, input bit pd, input bit sw, input bit sh);
    bit ev;
    ev   = st && !m_sp;
    m_sp = st;
    m_lu = 0;
    m_sn = 0;
    case (m_state)
      0: begin
        m_lives = T_START;
        if (ev) begin m_state = 1; m_score = 0; m_inv = 0; end
      end
      1: begin
        if (pd && m_inv == 0) begin
          if (m_lives > 1) begin m_lives = m_lives - 1; m_pause = T_PAUSE - 1; m_state = 2; end
          else begin m_lives = 0; m_state = 3; end
        end else begin
          if (m_inv > 0) m_inv = m_inv - 1;
          if (sw) begin m_sn = 1; if (m_score < 255) m_score = m_score + 1; end
          if (sw && !sh) m_lu = 2;
          else if (sh && !sw) m_lu = 1;
        end
      end
      2: begin
        if (m_pause == 0) begin m_state = 1; m_inv = T_INVULN; end
        else m_pause = m_pause - 1;
      end
      default: begin
        m_lives = 0;
        if (ev) begin m_state = 0; m_lives = T_START; end
      end
    endcase
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.st = 2'(m_state);
    e.lv = 2'(m_lives);
    e.pe = (m_state == 1);
    e.fl = (m_state == 1 && m_inv != 0) ? m_inv[2] : 1'b0;
    e.lu = 2'(m_lu);
    e.sn = 1'(m_sn);
    e.sc = SCORE_EN ? 8'(m_score) : 8'd0;
    e.go = (m_state == 3);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_next(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $error("FAIL %s scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, ".state"}, 8'(state), 8'(e.st));
    chk({tag, ".lives"}, 8'(lives), 8'(e.lv));
    chk({tag, ".play_enable"}, 8'(play_enable), 8'(e.pe));
    chk({tag, ".flash"}, 8'(flash), 8'(e.fl));
    chk({tag, ".length_update"}, 8'(length_update), 8'(e.lu));
    chk({tag, ".snare"}, 8'(snare_trigger), 8'(e.sn));
    chk({tag, ".score"}, score, e.sc);
    chk({tag, ".game_over"}, 8'(game_over), 8'(e.go));
    $display("txn %s st=%0d lv=%0d pe=%0b fl=%0b lu=%0d sn=%0b sc=%0d go=%0b", tag, state, lives,
             play_enable, flash, length_update, snare_trigger, score, game_over);
  endtask

  // One frame: sample cycle with frame_end, then a gap cycle with inputs held
  // so that any sampling outside frame_end would show up.
  task automatic frame(input bit st, input bit pd, input bit sw, input bit sh, input string tag);
    @(negedge clk);
    start = st; player_dragon_hit = pd; sword_dragon_hit = sw; sheep_dragon_hit = sh;
    frame_end = 1'b1;
    model_step(st, pd, sw, sh);
    sb.push_back(model_out());
    @(posedge clk); #1;
    check_next(tag);
    @(negedge clk);
    frame_end = 1'b0;
    m_lu = 0; m_sn = 0;
    sb.push_back(model_out());
    @(posedge clk); #1;
    check_next({tag, "_gap"});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; frame_end = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    sb.delete();
    sb.push_back(model_out());
    check_next("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #600000;
    $fatal(1, "FAIL watchdog expired");
  end

  initial begin
    rst_n = 1'b0; frame_end = 1'b0; start = 1'b0;
    player_dragon_hit = 1'b0; sword_dragon_hit = 1'b0; sheep_dragon_hit = 1'b0;
    model_reset();

    do_reset();
    chk("rst_state", 8'(state), 8'h00);
    chk("rst_lives", 8'(lives), 8'h03);
    chk("rst_play_enable", 8'(play_enable), 8'h00);
    chk("rst_game_over", 8'(game_over), 8'h00);
    chk("rst_score", score, 8'h00);

    // start held across reset is not an edge; release then press
    frame(1, 0, 0, 0, "start_no_edge");
    chk("no_edge_state", 8'(state), 8'h00);
    frame(0, 0, 0, 0, "start_release");
    frame(1, 0, 0, 0, "start_edge");
    chk("start_state", 8'(state), 8'h01);
    chk("start_lives", 8'(lives), 8'h03);
    chk("start_play_enable", 8'(play_enable), 8'h01);
    frame(0, 0, 0, 0, "idle_play");

    // sword/sheep combinations
    frame(0, 0, 1, 1, "sword_sheep");
    frame(0, 0, 1, 0, "sword_only");
    frame(0, 0, 0, 1, "sheep_only");
    frame(0, 0, 0, 0, "no_hit");

    // first player hit, pause with collisions ignored, invulnerability window
    frame(0, 1, 0, 0, "hit1");
    chk("hit1_state", 8'(state), 8'h02);
    chk("hit1_lives", 8'(lives), 8'h02);
    for (int i = 0; i < T_PAUSE - 1; i++) frame(0, 1, 1, 1, "pause1");
    chk("pause1_still_hit", 8'(state), 8'h02);
    frame(0, 1, 1, 1, "pause1_end");
    chk("pause1_back_play", 8'(state), 8'h01);
    for (int i = 0; i < T_INVULN; i++) frame(0, 1, 0, 0, "invuln1");
    chk("invuln1_lives", 8'(lives), 8'h02);
    frame(0, 1, 0, 0, "hit2");
    chk("hit2_lives", 8'(lives), 8'h01);
    for (int i = 0; i < T_PAUSE; i++) frame(0, 0, 0, 0, "pause2");
    for (int i = 0; i < T_INVULN; i++) frame(0, 0, 0, 0, "invuln2");

    // last life lost, sword in same frame suppressed
    frame(0, 1, 1, 1, "hit_last");
    chk("over_state", 8'(state), 8'h03);
    chk("over_lives", 8'(lives), 8'h00);
    chk("over_game_over", 8'(game_over), 8'h01);
    frame(0, 0, 1, 0, "over_ignore");
    frame(1, 0, 0, 0, "over_start");
    chk("over_to_idle", 8'(state), 8'h00);
    frame(0, 0, 0, 0, "idle_release");
    frame(1, 0, 0, 0, "restart");
    chk("restart_state", 8'(state), 8'h01);
    chk("restart_score", score, 8'h00);
    frame(0, 0, 0, 0, "restart_release");

    // score saturation
    for (int i = 0; i < 256; i++) frame(0, 0, 1, 0, "sword_run");
    chk("score_sat", score, SCORE_EN ? 8'hFF : 8'h00);

    // held start advances only one state
    do_reset();
    frame(0, 0, 0, 0, "held_pre");
    for (int i = 0; i < 10; i++) frame(1, 0, 0, 0, "held_start");
    chk("held_state", 8'(state), 8'h01);

    // reset mid-pause with coincident frame_end
    frame(0, 1, 0, 0, "hit_before_rst");
    for (int i = 0; i < 5; i++) frame(0, 0, 0, 0, "mid_pause");
    @(negedge clk);
    rst_n = 1'b0; frame_end = 1'b1; start = 1'b1; player_dragon_hit = 1'b1;
    @(posedge clk); #1;
    chk("midhit_rst_state", 8'(state), 8'h00);
    chk("midhit_rst_lives", 8'(lives), 8'h03);
    chk("midhit_rst_play_enable", 8'(play_enable), 8'h00);
    $display("txn midhit_reset st=%0d lv=%0d", state, lives);
    model_reset();
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1; frame_end = 1'b0; start = 1'b0; player_dragon_hit = 1'b0;
    frame(0, 0, 0, 0, "post_rst");
    frame(1, 0, 0, 0, "post_rst_start");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/game_flow_sequencer.md
GAME_FLOW_SEQUENCER -- requirements
Module: game_flow_sequencer

Interface
REQ-001 Parameter: START_LIVES, default 3, lives loaded at game start (legal 1..3).
REQ-002 Parameter: HIT_PAUSE_FRAMES, default 30, frames gameplay is frozen after a player hit (legal 1..255).
REQ-003 Parameter: INVULN_FRAMES, default 60, frames the player ignores dragon contact after the pause ends (legal 1..255).
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 frame_end  input  1  one-cycle pulse per video frame; the only event-sampling instant.
REQ-007 start  input  1  start/restart button level.
REQ-008 player_dragon_hit  input  1  player/dragon collision level.
REQ-009 sword_dragon_hit  input  1  sword/dragon collision level.
REQ-010 sheep_dragon_hit  input  1  sheep/dragon collision level.
REQ-011 state  output  2  00 IDLE, 01 PLAY, 10 HIT, 11 OVER.
REQ-012 lives  output  2  remaining lives, feeds the heart entity array count.
REQ-013 play_enable  output  1  high only in PLAY; gates player and dragon movement.
REQ-014 flash  output  1  player sprite blink during invulnerability.
REQ-015 length_update  output  2  one-cycle dragon length request: 01 grow, 10 shrink, 00 none.
REQ-016 snare_trigger  output  1  one-cycle pulse to the audio unit.
REQ-017 score  output  8  dragon-hit count.
REQ-018 game_over  output  1  high in OVER.

Function
REQ-019 Inputs SHALL be sampled only in cycles where frame_end=1; all outputs SHALL be registered and change in the following cycle (latency 1 clk).
REQ-020 start_prev SHALL capture start on each frame_end; a start event is start=1 with start_prev=0 at frame_end.
REQ-021 IDLE: lives=START_LIVES, play_enable=0; a start event -> PLAY, score cleared to 0, invulnerability counter cleared.
REQ-022 PLAY: player_dragon_hit=1 with invulnerability counter 0 and lives>1 -> lives decremented, pause counter loaded with HIT_PAUSE_FRAMES-1, state HIT.
REQ-023 PLAY: player_dragon_hit=1 with invulnerability counter 0 and lives=1 -> lives=0, state OVER.
REQ-024 PLAY, not leaving PLAY in that frame: sword_dragon_hit=1 -> snare_trigger pulse, length_update=10, score+1 saturating at 255.
REQ-025 PLAY, not leaving PLAY in that frame: sheep_dragon_hit=1 -> length_update=01; with sword_dragon_hit also 1, length_update=00 and the snare/score actions still occur.
REQ-026 A player hit in the same frame SHALL suppress sword and sheep actions.
REQ-027 length_update and snare_trigger SHALL each be high for exactly one clk per event, otherwise 0.
REQ-028 PLAY: invulnerability counter nonzero SHALL decrement by 1 per frame_end; player_dragon_hit is ignored while it is nonzero.
REQ-029 HIT: play_enable=0; pause counter decrements per frame_end; at frame_end with counter 0 -> PLAY and invulnerability counter loaded with INVULN_FRAMES.
REQ-030 flash SHALL equal bit 2 of the invulnerability counter when the counter is nonzero in PLAY, else 0.
REQ-031 OVER: game_over=1, play_enable=0, lives=0, score held; a start event -> IDLE.
REQ-032 A start level held continuously SHALL never advance more than one state.
REQ-033 Collision inputs in IDLE, HIT or OVER SHALL be ignored.

Reset
REQ-034 rst_n=0 at a clk edge SHALL force: state IDLE, lives START_LIVES, score 0, all counters 0, start_prev 1, and play_enable, flash, game_over, length_update and snare_trigger 0.
REQ-035 Reset SHALL take precedence over a coincident frame_end, in any state or mid-pause.

Configuration
REQ-036 Macro GAME_FLOW_SCORE_EN defined: score SHALL behave per REQ-021/024/031.
REQ-037 Macro absent: the score register SHALL NOT be built and score SHALL be constant 0; all other behaviour is unchanged.

Verification
REQ-038 Reset, then a start edge at frame_end -> state 01, lives 3, play_enable 1, one cycle later.
REQ-039 PLAY, player hit at one frame_end -> state 10, lives 2; 30 frames later state 01; a player hit during the next 60 frames is ignored; flash toggles every 4 frames.
REQ-040 PLAY with lives=1, player hit -> state 11, lives 0, game_over 1; start edge -> IDLE; a second edge -> PLAY with score 0.
REQ-041 PLAY, sword and sheep hits in the same frame -> snare_trigger 1 for one clk, length_update 00, score +1; sword-only -> 10; sheep-only -> 01.
REQ-042 255 sword hits -> score 255; a further hit -> score stays 255.
REQ-043 start held high for 10 frames from IDLE -> state PLAY only; rst_n low mid-HIT -> IDLE, lives 3, next cycle.
